// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a ready/valid instruction memory and presents
// fetched words to IF/ID. Uses a one-entry skid buffer, and an outstanding request can be discarded after a redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] next_instruction,
    output logic [31:0] supposed_next_address,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {FETCH, DRAIN, DISCARD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        imem_req_n;
    logic [31:0] imem_addr_n;
    logic        skid_valid, skid_valid_n;
    logic [31:0] skid_instruction, skid_instruction_n;
    logic [31:0] skid_address, skid_address_n;
    logic [31:0] next_instruction_n, supposed_next_address_n;
    logic        fetch_valid_n;

    logic        accept, slot_free;
    logic [31:0] target;

    assign accept    = imem_req && imem_ready;
    assign slot_free = !fetch_valid || !stall;
    assign target    = redirect_address & 32'hFFFF_FFFC;

    always_comb begin
        state_n                 = state;
        pc_n                    = pc;
        imem_req_n              = imem_req;
        imem_addr_n             = imem_addr;
        skid_valid_n            = skid_valid;
        skid_instruction_n      = skid_instruction;
        skid_address_n          = skid_address;
        next_instruction_n      = next_instruction;
        supposed_next_address_n = supposed_next_address;
        fetch_valid_n           = fetch_valid;

        if (redirect) begin
            pc_n               = target;
            fetch_valid_n      = 1'b0;
            next_instruction_n = 32'd0;
            skid_valid_n       = 1'b0;
            // An unanswered request must stay on the bus; its word is dropped later.
            if (imem_req && !imem_ready) begin
                state_n = DISCARD;
            end else begin
                state_n     = FETCH;
                imem_req_n  = 1'b1;
                imem_addr_n = target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc_n = pc + 32'd4;
                        if (slot_free) begin
                            next_instruction_n      = imem_rdata;
                            supposed_next_address_n = imem_addr + 32'd4;
                            fetch_valid_n           = 1'b1;
                            imem_req_n              = 1'b1;
                            imem_addr_n             = pc + 32'd4;
                        end else begin
                            skid_instruction_n = imem_rdata;
                            skid_address_n     = imem_addr + 32'd4;
                            skid_valid_n       = 1'b1;
                            imem_req_n         = 1'b0;
                            state_n            = DRAIN;
                        end
                    end else begin
                        if (!imem_req) begin
                            imem_req_n  = 1'b1;
                            imem_addr_n = pc;
                        end
                        if (!stall) fetch_valid_n = 1'b0;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        next_instruction_n      = skid_instruction;
                        supposed_next_address_n = skid_address;
                        fetch_valid_n           = 1'b1;
                        skid_valid_n            = 1'b0;
                        imem_req_n              = 1'b1;
                        imem_addr_n             = pc;
                        state_n                 = FETCH;
                    end
                end
                DISCARD: begin
                    if (accept) begin
                        imem_req_n  = 1'b1;
                        imem_addr_n = pc;
                        state_n     = FETCH;
                    end
                    if (!stall) fetch_valid_n = 1'b0;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= FETCH;
            pc                    <= RESET_PC;
            imem_req              <= 1'b0;
            imem_addr             <= RESET_PC;
            skid_valid            <= 1'b0;
            skid_instruction      <= 32'd0;
            skid_address          <= 32'd0;
            next_instruction      <= 32'd0;
            supposed_next_address <= 32'd0;
            fetch_valid           <= 1'b0;
        end else begin
            state                 <= state_n;
            pc                    <= pc_n;
            imem_req              <= imem_req_n;
            imem_addr             <= imem_addr_n;
            skid_valid            <= skid_valid_n;
            skid_instruction      <= skid_instruction_n;
            skid_address          <= skid_address_n;
            next_instruction      <= next_instruction_n;
            supposed_next_address <= supposed_next_address_n;
            fetch_valid           <= fetch_valid_n;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run checked against a program-order stream model and a request-hold rule.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_ready;
    logic [31:0] redirect_address;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] next_instruction, supposed_next_address;
    logic        fetch_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .stall                 (stall),
        .redirect              (redirect),
        .redirect_address      (redirect_address),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_ready            (imem_ready),
        .imem_rdata            (imem_rdata),
        .next_instruction      (next_instruction),
        .supposed_next_address (supposed_next_address),
        .fetch_valid           (fetch_valid)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        redirect_address = 32'd0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        redirect_address = 32'd0;
        cyc(); cyc();
        tests++;
        if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || next_instruction !== 32'd0 ||
            supposed_next_address !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: req=%b fv=%b instr=%h sna=%h, want 0 0 0 0",
                     imem_req, fetch_valid, next_instruction, supposed_next_address);
        end
        reset = 1'b0;
        cyc();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_release: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if (fetch_valid !== 1'b1 || next_instruction !== mem_word(32'(4 * i)) ||
                supposed_next_address !== 32'(4 * i + 4)) begin
                fails++;
                $display("FAIL zero_wait[%0d]: fv=%b instr=%h sna=%h, want 1 %h %h", i,
                         fetch_valid, next_instruction, supposed_next_address,
                         mem_word(32'(4 * i)), 32'(4 * i + 4));
            end
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_stall_skid();
        do_reset();
        imem_ready = 1'b1;
        cyc();
        stall = 1'b1;
        cyc();
        tests++;
        if (fetch_valid !== 1'b1 || next_instruction !== mem_word(32'd0) ||
            supposed_next_address !== 32'd4 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL skid_hold: fv=%b instr=%h sna=%h req=%b, want 1 %h 00000004 0",
                     fetch_valid, next_instruction, supposed_next_address, imem_req,
                     mem_word(32'd0));
        end
        imem_ready = 1'b0;
        cyc();
        tests++;
        if (imem_req !== 1'b0 || next_instruction !== mem_word(32'd0)) begin
            fails++;
            $display("FAIL skid_hold2: req=%b instr=%h, want 0 %h", imem_req,
                     next_instruction, mem_word(32'd0));
        end
        stall = 1'b0;
        cyc();
        tests++;
        if (fetch_valid !== 1'b1 || next_instruction !== mem_word(32'd4) ||
            supposed_next_address !== 32'd8 || imem_req !== 1'b1 || imem_addr !== 32'd8) begin
            fails++;
            $display("FAIL skid_drain: fv=%b instr=%h sna=%h req=%b addr=%h, want 1 %h 00000008 1 00000008",
                     fetch_valid, next_instruction, supposed_next_address, imem_req, imem_addr,
                     mem_word(32'd4));
        end
        imem_ready = 1'b1;
        cyc();
        tests++;
        if (fetch_valid !== 1'b1 || next_instruction !== mem_word(32'd8) ||
            supposed_next_address !== 32'd12) begin
            fails++;
            $display("FAIL skid_next: fv=%b instr=%h sna=%h, want 1 %h 0000000c",
                     fetch_valid, next_instruction, supposed_next_address, mem_word(32'd8));
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_ready = 1'b1;
        cyc(); cyc();
        imem_ready = 1'b0;
        redirect = 1'b1; redirect_address = 32'h0000_0103;
        cyc();
        redirect = 1'b0;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd8 || fetch_valid !== 1'b0 ||
            next_instruction !== 32'd0) begin
            fails++;
            $display("FAIL redirect_hold: req=%b addr=%h fv=%b instr=%h, want 1 00000008 0 0",
                     imem_req, imem_addr, fetch_valid, next_instruction);
        end
        cyc();
        tests++;
        if (imem_addr !== 32'd8 || fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_hold2: addr=%h fv=%b, want 00000008 0", imem_addr, fetch_valid);
        end
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        tests++;
        if (imem_addr !== 32'h0000_0100 || imem_req !== 1'b1 || fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_drop: addr=%h req=%b fv=%b, want 00000100 1 0",
                     imem_addr, imem_req, fetch_valid);
        end
        cyc();
        tests++;
        if (fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_bubble: fv=%b, want 0", fetch_valid);
        end
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        tests++;
        if (fetch_valid !== 1'b1 || next_instruction !== mem_word(32'h100) ||
            supposed_next_address !== 32'h104) begin
            fails++;
            $display("FAIL redirect_target: fv=%b instr=%h sna=%h, want 1 %h 00000104",
                     fetch_valid, next_instruction, supposed_next_address, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_accept();
        do_reset();
        imem_ready = 1'b1; redirect = 1'b1; redirect_address = 32'h0000_0040;
        cyc();
        redirect = 1'b0;
        tests++;
        if (fetch_valid !== 1'b0 || next_instruction !== 32'd0 || imem_addr !== 32'h40 ||
            imem_req !== 1'b1) begin
            fails++;
            $display("FAIL redir_accept: fv=%b instr=%h addr=%h req=%b, want 0 0 00000040 1",
                     fetch_valid, next_instruction, imem_addr, imem_req);
        end
        cyc();
        tests++;
        if (fetch_valid !== 1'b1 || next_instruction !== mem_word(32'h40) ||
            supposed_next_address !== 32'h44) begin
            fails++;
            $display("FAIL redir_accept_next: fv=%b instr=%h sna=%h, want 1 %h 00000044",
                     fetch_valid, next_instruction, supposed_next_address, mem_word(32'h40));
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b1; redirect = 1'b1; redirect_address = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        cyc();
        imem_ready = 1'b0;
        tests++;
        if (fetch_valid !== 1'b1 || next_instruction !== mem_word(32'hFFFF_FFFC) ||
            supposed_next_address !== 32'd0 || imem_addr !== 32'd0) begin
            fails++;
            $display("FAIL wrap: fv=%b instr=%h sna=%h addr=%h, want 1 %h 00000000 00000000",
                     fetch_valid, next_instruction, supposed_next_address, imem_addr,
                     mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_reset_drain();
        do_reset();
        imem_ready = 1'b1;
        cyc();
        stall = 1'b1;
        cyc();
        reset = 1'b1; redirect = 1'b1; redirect_address = 32'h0000_0080;
        cyc();
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0 || fetch_valid !== 1'b0 ||
            next_instruction !== 32'd0 || supposed_next_address !== 32'd0) begin
            fails++;
            $display("FAIL reset_drain: req=%b addr=%h fv=%b instr=%h sna=%h, want all 0",
                     imem_req, imem_addr, fetch_valid, next_instruction, supposed_next_address);
        end
        reset = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        cyc();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_drain_release: req=%b addr=%h fv=%b, want 1 00000000 0",
                     imem_req, imem_addr, fetch_valid);
        end
        stall = 1'b0;
    endtask

    // Consumed instructions must follow program order from RESET_PC, restarting
    // at the aligned target after each redirect; pending requests must not move.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_pending;
        int          consumed;
        do_reset();
        exp_pc = 32'd0; prev_addr = 32'd0; prev_pending = 1'b0; consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (prev_pending) begin
                tests++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    fails++;
                    $display("FAIL random_hold[%0d]: req=%b addr=%h, want 1 %h", i,
                             imem_req, imem_addr, prev_addr);
                end
            end
            stall            = ($urandom_range(0, 99) < 40);
            imem_ready       = ($urandom_range(0, 99) < 50);
            redirect         = ($urandom_range(0, 99) < 5);
            redirect_address = $urandom;
            if (fetch_valid === 1'b1 && !stall && !redirect) begin
                tests++;
                if (next_instruction !== mem_word(exp_pc) ||
                    supposed_next_address !== exp_pc + 32'd4) begin
                    fails++;
                    $display("FAIL random_stream[%0d]: instr=%h sna=%h, want %h %h", i,
                             next_instruction, supposed_next_address, mem_word(exp_pc),
                             exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redirect) exp_pc = redirect_address & 32'hFFFF_FFFC;
            prev_pending = imem_req && !imem_ready;
            prev_addr    = imem_addr;
            cyc();
        end
        tests++;
        if (consumed < 200) begin
            fails++;
            $display("FAIL random_progress: consumed %0d, want at least 200", consumed);
        end
        stall = 1'b0; imem_ready = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        redirect_address = 32'd0;
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_accept();
        test_wrap();
        test_reset_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall  input  1  downstream IF/ID cannot accept; hold presented instruction.
REQ-005 SHALL have port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-006 SHALL have port: redirect_address  input  32  new fetch target.
REQ-007 SHALL have port: imem_req  output  1  instruction memory request.
REQ-008 SHALL have port: imem_addr  output  32  request address.
REQ-009 SHALL have port: imem_ready  input  1  response valid; completes the request.
REQ-010 SHALL have port: imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-011 SHALL have port: next_instruction  output  32  presented instruction, feeds IF/ID.
REQ-012 SHALL have port: supposed_next_address  output  32  presented instruction address + 4, feeds IF/ID.
REQ-013 SHALL have port: fetch_valid  output  1  presented instruction is real (0 = bubble).

Function
REQ-014 SHALL register all outputs; no combinational path from stall, redirect or imem_ready to any output.
REQ-015 SHALL accept a response only in a cycle with imem_req=1 and imem_ready=1; memory latency is unbounded, zero-wait allowed.
REQ-016 SHALL hold imem_addr and imem_req stable from assertion until the accepting cycle, including across redirect.
REQ-017 SHALL keep fetch pointer pc; imem_addr = pc; on acceptance pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 SHALL treat output slot as free when fetch_valid=0 or stall=0.
REQ-019 SHALL, on an accepted non-discarded response with slot free, load next_instruction <= imem_rdata, supposed_next_address <= request address + 4, fetch_valid <= 1.
REQ-020 SHALL, on an accepted response with slot not free, store word and address+4 in a one-entry skid buffer and set skid_valid.
REQ-021 SHALL deassert imem_req while skid_valid=1; when stall=0 with skid_valid=1, move skid to outputs, clear skid_valid, resume requesting next cycle.
REQ-022 SHALL, when stall=0 and no new word or skid entry is loaded, set fetch_valid <= 0 (bubble); outputs hold data.
REQ-023 SHALL implement states FETCH (requesting), DRAIN (skid full, no request), DISCARD (outstanding request to be dropped): FETCH->DRAIN on REQ-020; DRAIN->FETCH on drain; FETCH->DISCARD on redirect with outstanding unready request; DISCARD->FETCH on next acceptance.
REQ-024 SHALL give redirect priority over stall and responses: pc <= {redirect_address[31:2],2'b00}, fetch_valid <= 0, next_instruction <= 0, skid_valid <= 0.
REQ-025 SHALL, if redirect coincides with acceptance, drop that response and request the new pc next cycle.
REQ-026 SHALL, in DISCARD, keep old imem_addr until acceptance, drop that word, then issue redirect target; a second redirect in DISCARD updates pc only.

Reset
REQ-027 SHALL, when reset=1 at a clk edge, set pc=RESET_PC, state FETCH, skid_valid=0, next_instruction=0, supposed_next_address=0, fetch_valid=0, imem_req=0; imem_req asserts the cycle after reset deasserts.
REQ-028 SHALL abandon any outstanding request on reset and have reset override all inputs, including redirect.

Verification
REQ-029 SHALL pass: zero-wait memory, stall=0, words A,B,C -> fetch_valid=1 three cycles, supposed_next_address 4,8,12 from RESET_PC=0.
REQ-030 SHALL pass: stall=1 with response arriving -> outputs hold, skid takes word, imem_req=0; stall=0 -> skid word presented next cycle, no loss or duplicate.
REQ-031 SHALL pass: redirect to 32'h0000_0103 while request to 8 awaits ready 3 cycles -> word from 8 dropped, next imem_addr=32'h0000_0100, fetch_valid=0 until it returns.
REQ-032 SHALL pass: redirect same cycle as imem_ready -> word dropped, imem_addr = redirect target next cycle.
REQ-033 SHALL pass: pc=32'hFFFF_FFFC accepted -> supposed_next_address=0, next imem_addr=0.
REQ-034 SHALL pass: reset asserted mid-DRAIN with stall=1 -> all outputs 0, fetch_valid=0; first request after release to RESET_PC.
